// File: rtl/mips32_trace_pkg.sv
// Shared types, field widths and record layout for the mips32 pipeline trace buffer.
package mips32_trace_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } traceState_t;

  localparam int unsigned DEF_DEPTH      = 16;
  localparam int unsigned DEF_RUN_LIMIT  = 16;
  localparam int unsigned DEF_CTRL_W     = 12;
  localparam int unsigned DEF_MEM_ADDR_W = 14;
  localparam int unsigned DEF_DATA_W     = 32;
  localparam int unsigned DEF_REG_ADDR_W = 5;
  localparam int unsigned DEF_PC_W       = 32;
  localparam int unsigned DEF_INSTR_W    = 32;
  localparam int unsigned DEF_TS_W       = 16;

  function automatic int unsigned recWidth(
    input int unsigned tsW,
    input int unsigned ctrlW,
    input int unsigned memAddrW,
    input int unsigned dataW,
    input int unsigned regAddrW,
    input int unsigned pcW,
    input int unsigned instrW
  );
    return tsW + ctrlW + memAddrW + 2 * dataW + regAddrW + pcW + 2 * instrW;
  endfunction

  localparam int unsigned DEF_REC_W = recWidth(DEF_TS_W, DEF_CTRL_W, DEF_MEM_ADDR_W, DEF_DATA_W,
                                               DEF_REG_ADDR_W, DEF_PC_W, DEF_INSTR_W);

  // LSB offsets of each field inside a default-width record
  localparam int unsigned OFF_INSTR_ID = 0;
  localparam int unsigned OFF_INSTR_IF = OFF_INSTR_ID + DEF_INSTR_W;
  localparam int unsigned OFF_NEXT_PC  = OFF_INSTR_IF + DEF_INSTR_W;
  localparam int unsigned OFF_BR_DATA  = OFF_NEXT_PC + DEF_PC_W;
  localparam int unsigned OFF_BR_ADDR  = OFF_BR_DATA + DEF_DATA_W;
  localparam int unsigned OFF_MEM_DATA = OFF_BR_ADDR + DEF_REG_ADDR_W;
  localparam int unsigned OFF_MEM_ADDR = OFF_MEM_DATA + DEF_DATA_W;
  localparam int unsigned OFF_CTRL     = OFF_MEM_ADDR + DEF_MEM_ADDR_W;
  localparam int unsigned OFF_TS       = OFF_CTRL + DEF_CTRL_W;

endpackage

// File: rtl/mips32_trace_buffer_if.sv
// Debug-tap, control and read-back signal bundle of the trace buffer.
interface mips32_trace_buffer_if
  import mips32_trace_pkg::*;
#(
  parameter int unsigned DEPTH      = DEF_DEPTH,
  parameter int unsigned CTRL_W     = DEF_CTRL_W,
  parameter int unsigned MEM_ADDR_W = DEF_MEM_ADDR_W,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int unsigned PC_W       = DEF_PC_W,
  parameter int unsigned INSTR_W    = DEF_INSTR_W,
  parameter int unsigned TS_W       = DEF_TS_W
) ();

  localparam int unsigned REC_W = recWidth(TS_W, CTRL_W, MEM_ADDR_W, DATA_W, REG_ADDR_W, PC_W, INSTR_W);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic                  arm;
  logic                  mode_wrap;
  logic                  sample_en;
  logic [CTRL_W-1:0]     ctrl_code;
  logic [MEM_ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0]     mem_data;
  logic [REG_ADDR_W-1:0] br_addr;
  logic [DATA_W-1:0]     br_data;
  logic [PC_W-1:0]       next_pc;
  logic [INSTR_W-1:0]    instr_if;
  logic [INSTR_W-1:0]    instr_id;
  logic                  rd_req;
  logic                  rd_valid;
  logic [REC_W-1:0]      rd_data;
  logic                  rd_last;
  logic [CNT_W-1:0]      count;
  logic [1:0]            state;
  logic                  done;
  logic                  overflow;

  modport master (
    output arm, mode_wrap, sample_en, ctrl_code, mem_addr, mem_data, br_addr, br_data,
           next_pc, instr_if, instr_id, rd_req,
    input  rd_valid, rd_data, rd_last, count, state, done, overflow
  );

  modport slave (
    input  arm, mode_wrap, sample_en, ctrl_code, mem_addr, mem_data, br_addr, br_data,
           next_pc, instr_if, instr_id, rd_req,
    output rd_valid, rd_data, rd_last, count, state, done, overflow
  );

endinterface

// File: rtl/mips32_trace_ram.sv
// Simple dual-port record store: one write port, one registered read port.
module mips32_trace_ram #(
  parameter  int unsigned DEPTH = 16,
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    wAddr,
  input  logic [WIDTH-1:0] wData,
  input  logic             re,
  input  logic [AW-1:0]    rAddr,
  output logic [WIDTH-1:0] rData
);

  logic [WIDTH-1:0] mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (we) mem[wAddr] <= wData;
  end

  // Read register only loads on a request, so the last record stays visible
  always_ff @(posedge clk) begin
    if (rst)     rData <= '0;
    else if (re) rData <= mem[rAddr];
  end

endmodule

// File: rtl/mips32_trace_buffer.sv
// On-chip trace capture of mips32 pipeline debug taps into a circular record buffer.
// Optional macro TRACE_TRIGGER_PC_EN: arm waits in ARMED until next_pc hits TRIGGER_PC.
module mips32_trace_buffer
  import mips32_trace_pkg::*;
#(
  parameter int unsigned DEPTH      = DEF_DEPTH,
  parameter int unsigned RUN_LIMIT  = DEF_RUN_LIMIT,
  parameter int unsigned CTRL_W     = DEF_CTRL_W,
  parameter int unsigned MEM_ADDR_W = DEF_MEM_ADDR_W,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int unsigned PC_W       = DEF_PC_W,
  parameter int unsigned INSTR_W    = DEF_INSTR_W,
  parameter int unsigned TS_W       = DEF_TS_W,
  parameter logic [31:0] TRIGGER_PC = 32'h0
) (
  input logic                  clk,
  input logic                  rst,
  mips32_trace_buffer_if.slave bus
);

  localparam int unsigned REC_W = recWidth(TS_W, CTRL_W, MEM_ADDR_W, DATA_W, REG_ADDR_W, PC_W, INSTR_W);
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CNT_W = AW + 1;

`ifdef TRACE_TRIGGER_PC_EN
  localparam traceState_t ARM_NEXT = ARMED;
`else
  localparam traceState_t ARM_NEXT = CAPTURE;
`endif

  traceState_t      stateQ, stateD;
  logic [AW-1:0]    wrPtr, rdPtr;
  logic [CNT_W-1:0] countQ;
  logic [TS_W-1:0]  tsQ;
  logic [31:0]      sampleCnt;
  logic             wrapMode;
  logic             overflowQ;
  logic             rdValidQ;
  logic             rdLastQ;
  logic             doneD;

  logic             armOk, trigHit, capActive, wrEn, full, limitHit, fillHit, stopHit, rdAccept;
  logic [REC_W-1:0] wrRec, ramRdData;

  assign armOk     = bus.arm && ((stateQ == IDLE) || ((stateQ == DONE) && (countQ == '0)));
  // ARMED is never entered without the trigger macro, so this stays low there
  assign trigHit   = (stateQ == ARMED) && bus.sample_en && (bus.next_pc == PC_W'(TRIGGER_PC));
  assign capActive = (stateQ == CAPTURE) || trigHit;
  assign wrEn      = capActive && bus.sample_en;
  assign full      = (countQ == CNT_W'(DEPTH));
  assign limitHit  = (RUN_LIMIT != 0) && (sampleCnt == 32'(RUN_LIMIT - 1));
  assign fillHit   = !wrapMode && (countQ == CNT_W'(DEPTH - 1));
  assign stopHit   = wrEn && (limitHit || fillHit);
  assign rdAccept  = (stateQ == DONE) && bus.rd_req && (countQ != '0);

  assign wrRec = {tsQ, bus.ctrl_code, bus.mem_addr, bus.mem_data, bus.br_addr, bus.br_data,
                  bus.next_pc, bus.instr_if, bus.instr_id};

  always_ff @(posedge clk) begin
    if (rst) stateQ <= IDLE;
    else     stateQ <= stateD;
  end

  always_comb begin
    stateD = stateQ;
    case (stateQ)
      IDLE:    if (armOk) stateD = ARM_NEXT;
      ARMED: begin
        if (stopHit)      stateD = DONE;
        else if (trigHit) stateD = CAPTURE;
      end
      CAPTURE: if (stopHit) stateD = DONE;
      DONE:    if (armOk) stateD = ARM_NEXT;
      default: stateD = IDLE;
    endcase
  end

  always_comb begin
    doneD = (stateQ == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      countQ    <= '0;
      tsQ       <= '0;
      sampleCnt <= '0;
      wrapMode  <= 1'b0;
      overflowQ <= 1'b0;
      rdValidQ  <= 1'b0;
      rdLastQ   <= 1'b0;
    end else begin
      rdValidQ <= rdAccept;
      rdLastQ  <= rdAccept && (countQ == CNT_W'(1));
      if (armOk) begin
        wrPtr     <= '0;
        rdPtr     <= '0;
        countQ    <= '0;
        tsQ       <= '0;
        sampleCnt <= '0;
        overflowQ <= 1'b0;
        wrapMode  <= bus.mode_wrap;
      end else begin
        if (capActive) tsQ <= tsQ + 1'b1;
        if (wrEn) begin
          wrPtr     <= wrPtr + 1'b1;
          sampleCnt <= sampleCnt + 32'd1;
          if (!full) begin
            countQ <= countQ + 1'b1;
          end else if (wrapMode) begin
            // Full ring in wrap mode: the write lands on the oldest slot
            rdPtr     <= rdPtr + 1'b1;
            overflowQ <= 1'b1;
          end
        end
        if (rdAccept) begin
          rdPtr  <= rdPtr + 1'b1;
          countQ <= countQ - 1'b1;
        end
      end
    end
  end

  mips32_trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (REC_W)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wrEn),
    .wAddr (wrPtr),
    .wData (wrRec),
    .re    (rdAccept),
    .rAddr (rdPtr),
    .rData (ramRdData)
  );

  assign bus.rd_valid = rdValidQ;
  assign bus.rd_data  = ramRdData;
  assign bus.rd_last  = rdLastQ;
  assign bus.count    = countQ;
  assign bus.state    = stateQ;
  assign bus.done     = doneD;
  assign bus.overflow = overflowQ;

endmodule

// File: tb/tb_mips32_trace_buffer.sv
// Randomized self-checking bench: four trace buffers with different run limits vs. a queue model.
module tb_mips32_trace_buffer;
  import mips32_trace_pkg::*;

  localparam int unsigned REC_W = DEF_REC_W;
  localparam int unsigned NDUT  = 4;
`ifdef TRACE_TRIGGER_PC_EN
  localparam logic [1:0] ARM_EXP = 2'd1;
`else
  localparam logic [1:0] ARM_EXP = 2'd2;
`endif

  function automatic int unsigned limitOf(input int g);
    case (g)
      0:       return 16;
      1:       return 20;
      2:       return 0;
      default: return 8;
    endcase
  endfunction

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        armV [NDUT];
  logic        rdReqV [NDUT];
  logic        modeWrap, sampleEn;
  logic [11:0] ctrlCode;
  logic [13:0] memAddr;
  logic [31:0] memData, brData, nextPc, instrIf, instrId;
  logic [4:0]  brAddr;

  logic [1:0]       stateV [NDUT];
  logic [4:0]       countV [NDUT];
  logic             doneV [NDUT], ovfV [NDUT], rdValidV [NDUT], rdLastV [NDUT];
  logic [REC_W-1:0] rdDataV [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : gDut
    mips32_trace_buffer_if #(.DEPTH(16)) bus ();
    assign bus.arm       = armV[g];
    assign bus.rd_req    = rdReqV[g];
    assign bus.mode_wrap = modeWrap;
    assign bus.sample_en = sampleEn;
    assign bus.ctrl_code = ctrlCode;
    assign bus.mem_addr  = memAddr;
    assign bus.mem_data  = memData;
    assign bus.br_addr   = brAddr;
    assign bus.br_data   = brData;
    assign bus.next_pc   = nextPc;
    assign bus.instr_if  = instrIf;
    assign bus.instr_id  = instrId;
    assign stateV[g]   = bus.state;
    assign countV[g]   = bus.count;
    assign doneV[g]    = bus.done;
    assign ovfV[g]     = bus.overflow;
    assign rdValidV[g] = bus.rd_valid;
    assign rdLastV[g]  = bus.rd_last;
    assign rdDataV[g]  = bus.rd_data;

    mips32_trace_buffer #(
      .DEPTH      (16),
      .RUN_LIMIT  (limitOf(g)),
      .TRIGGER_PC (32'h40)
    ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
  end

  int checks = 0;
  int errors = 0;

  // Reference model: the records that should be held, oldest first
  logic [REC_W-1:0] expQ [$];
  bit               expOvf, expDone;

  // Arms instance g and presents nCyc capture cycles; enMode 0=always, 1=every other, 2=random.
  // The first sample carries next_pc=0x40 so the trigger build starts on the same cycle.
  task automatic drive_capture(input int g, input bit wrap, input int nCyc, input int enMode,
                               output logic [1:0] armState);
    int unsigned samples = 0;
    bit en;
    expQ.delete();
    expOvf  = 1'b0;
    expDone = 1'b0;
    @(negedge clk);
    armV[g] = 1'b1; modeWrap = wrap; sampleEn = 1'b0;
    @(negedge clk);
    armV[g] = 1'b0; modeWrap = 1'($urandom_range(0, 1));
    armState = stateV[g];
    for (int k = 0; k < nCyc; k++) begin
      if (enMode == 0)      en = 1'b1;
      else if (enMode == 1) en = (k % 2 == 0);
      else                  en = (k == 0) || ($urandom_range(0, 3) != 0);
      sampleEn = en;
      ctrlCode = 12'(k);
      nextPc   = (k == 0) ? 32'h40 : $urandom;
      memAddr  = 14'($urandom);
      memData  = $urandom;
      brAddr   = 5'($urandom);
      brData   = $urandom;
      instrIf  = $urandom;
      instrId  = $urandom;
      if (!expDone && en) begin
        expQ.push_back({16'(k), ctrlCode, memAddr, memData, brAddr, brData, nextPc, instrIf, instrId});
        samples++;
        if (expQ.size() > 16) begin
          void'(expQ.pop_front());
          expOvf = 1'b1;
        end
        if ((limitOf(g) != 0 && samples == limitOf(g)) || (!wrap && expQ.size() == 16)) expDone = 1'b1;
      end
      @(negedge clk);
    end
    sampleEn = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int g = 0; g < NDUT; g++) begin
      checks++;
      if ({stateV[g], countV[g], doneV[g], ovfV[g], rdValidV[g], rdLastV[g]} !== 11'd0) begin
        errors++;
        $display("FAIL reset_outputs dut%0d got state=%0d count=%0d done=%b ovf=%b valid=%b last=%b exp all 0",
                 g, stateV[g], countV[g], doneV[g], ovfV[g], rdValidV[g], rdLastV[g]);
      end
      checks++;
      if (rdDataV[g] !== '0) begin
        errors++; $display("FAIL reset_rd_data dut%0d got %h exp 0", g, rdDataV[g]);
      end
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [1:0] st;
    logic [REC_W-1:0] r;
    drive_capture(0, 1'b0, 16, 0, st);
    checks++;
    if (st !== ARM_EXP) begin errors++; $display("FAIL basic_arm_state got %0d exp %0d", st, ARM_EXP); end
    checks++;
    if ({doneV[0], stateV[0], countV[0], ovfV[0]} !== {1'b1, 2'd3, 5'd16, 1'b0}) begin
      errors++; $display("FAIL basic_done got done=%b state=%0d count=%0d ovf=%b exp 1/3/16/0",
                         doneV[0], stateV[0], countV[0], ovfV[0]);
    end
    armV[0] = 1'b1; @(negedge clk); armV[0] = 1'b0; @(negedge clk);
    checks++;
    if (stateV[0] !== 2'd3 || countV[0] !== 5'd16) begin
      errors++; $display("FAIL basic_arm_ignored got state=%0d count=%0d exp 3/16", stateV[0], countV[0]);
    end
    rdReqV[0] = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      r = rdDataV[0];
      checks++;
      if (rdValidV[0] !== 1'b1 || r !== expQ[i]) begin
        errors++; $display("FAIL basic_rec%0d got valid=%b %h exp %h", i, rdValidV[0], r, expQ[i]);
      end
      checks++;
      if (r[OFF_CTRL +: 12] !== 12'(i) || r[OFF_TS +: 16] !== 16'(i)) begin
        errors++; $display("FAIL basic_fields%0d got ctrl=%0d ts=%0d exp %0d/%0d",
                           i, r[OFF_CTRL +: 12], r[OFF_TS +: 16], i, i);
      end
      checks++;
      if (rdLastV[0] !== 1'(i == 15)) begin
        errors++; $display("FAIL basic_last%0d got %b exp %b", i, rdLastV[0], (i == 15));
      end
    end
    rdReqV[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (rdValidV[0] !== 1'b0 || rdDataV[0] !== expQ[15] || countV[0] !== 5'd0 || doneV[0] !== 1'b1) begin
      errors++; $display("FAIL basic_after_read got valid=%b count=%0d done=%b data=%h exp 0/0/1/%h",
                         rdValidV[0], countV[0], doneV[0], rdDataV[0], expQ[15]);
    end
  endtask

  task automatic test_wrap();
    logic [1:0] st;
    logic [REC_W-1:0] r;
    drive_capture(1, 1'b1, 20, 0, st);
    checks++;
    if ({doneV[1], countV[1], ovfV[1]} !== {1'b1, 5'd16, 1'b1}) begin
      errors++; $display("FAIL wrap_done got done=%b count=%0d ovf=%b exp 1/16/1", doneV[1], countV[1], ovfV[1]);
    end
    rdReqV[1] = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      r = rdDataV[1];
      checks++;
      if (rdValidV[1] !== 1'b1 || r !== expQ[i] || r[OFF_CTRL +: 12] !== 12'(i + 4)) begin
        errors++; $display("FAIL wrap_rec%0d got valid=%b %h exp ctrl %0d %h", i, rdValidV[1], r, i + 4, expQ[i]);
      end
    end
    rdReqV[1] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_no_limit();
    logic [1:0] st;
    logic [REC_W-1:0] r;
    drive_capture(2, 1'b0, 24, 0, st);
    checks++;
    if ({doneV[2], countV[2], ovfV[2]} !== {1'b1, 5'd16, 1'b0}) begin
      errors++; $display("FAIL nolimit_done got done=%b count=%0d ovf=%b exp 1/16/0", doneV[2], countV[2], ovfV[2]);
    end
    rdReqV[2] = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      r = rdDataV[2];
      checks++;
      if (rdValidV[2] !== 1'b1 || r !== expQ[i] || r[OFF_CTRL +: 12] !== 12'(i)) begin
        errors++; $display("FAIL nolimit_rec%0d got valid=%b %h exp %h", i, rdValidV[2], r, expQ[i]);
      end
    end
    repeat (2) @(negedge clk);
    checks++;
    if (rdValidV[2] !== 1'b0 || rdDataV[2] !== expQ[15]) begin
      errors++; $display("FAIL nolimit_empty_req got valid=%b data=%h exp 0/%h", rdValidV[2], rdDataV[2], expQ[15]);
    end
    rdReqV[2] = 1'b0;
  endtask

  task automatic test_toggle();
    logic [1:0] st;
    logic [REC_W-1:0] r;
    drive_capture(3, 1'b0, 16, 1, st);
    checks++;
    if ({doneV[3], countV[3]} !== {1'b1, 5'd8}) begin
      errors++; $display("FAIL toggle_done got done=%b count=%0d exp 1/8", doneV[3], countV[3]);
    end
    rdReqV[3] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      r = rdDataV[3];
      checks++;
      if (rdValidV[3] !== 1'b1 || r !== expQ[i] || r[OFF_TS +: 16] !== 16'(2 * i) || rdLastV[3] !== 1'(i == 7)) begin
        errors++; $display("FAIL toggle_rec%0d got valid=%b last=%b ts=%0d exp ts %0d", i, rdValidV[3],
                           rdLastV[3], r[OFF_TS +: 16], 2 * i);
      end
    end
    rdReqV[3] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_rearm();
    logic [1:0] st;
    logic [REC_W-1:0] r;
    int n;
    drive_capture(0, 1'($urandom_range(0, 1)), 40, 2, st);
    checks++;
    if (st !== ARM_EXP) begin errors++; $display("FAIL rearm_state got %0d exp %0d", st, ARM_EXP); end
    n = expQ.size();
    checks++;
    if (doneV[0] !== expDone || countV[0] !== 5'(n) || ovfV[0] !== expOvf) begin
      errors++; $display("FAIL rearm_status got done=%b count=%0d ovf=%b exp %b/%0d/%b",
                         doneV[0], countV[0], ovfV[0], expDone, n, expOvf);
    end
    if (expDone) begin
      rdReqV[0] = 1'b1;
      for (int i = 0; i < n; i++) begin
        @(negedge clk);
        r = rdDataV[0];
        checks++;
        if (rdValidV[0] !== 1'b1 || r !== expQ[i] || rdLastV[0] !== 1'(i == n - 1)) begin
          errors++; $display("FAIL rearm_rec%0d got valid=%b last=%b %h exp %h", i, rdValidV[0], rdLastV[0], r, expQ[i]);
        end
      end
      rdReqV[0] = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] st;
    drive_capture(2, 1'b0, 5, 0, st);
    checks++;
    if (countV[2] !== 5'd5 || stateV[2] !== 2'd2) begin
      errors++; $display("FAIL midrst_pre got count=%0d state=%0d exp 5/2", countV[2], stateV[2]);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({stateV[2], countV[2], doneV[2], ovfV[2], rdValidV[2], rdLastV[2]} !== 11'd0 || rdDataV[2] !== '0) begin
      errors++; $display("FAIL midrst_outputs got state=%0d count=%0d done=%b ovf=%b valid=%b data=%h exp all 0",
                         stateV[2], countV[2], doneV[2], ovfV[2], rdValidV[2], rdDataV[2]);
    end
    rdReqV[2] = 1'b1;
    @(negedge clk);
    rdReqV[2] = 1'b0;
    checks++;
    if (rdValidV[2] !== 1'b0 || stateV[2] !== 2'd0) begin
      errors++; $display("FAIL midrst_rd_req got valid=%b state=%0d exp 0/0", rdValidV[2], stateV[2]);
    end
    @(negedge clk);
  endtask

`ifdef TRACE_TRIGGER_PC_EN
  task automatic test_trigger();
    logic [REC_W-1:0] r;
    @(negedge clk);
    armV[0] = 1'b1; modeWrap = 1'b0; sampleEn = 1'b0;
    @(negedge clk);
    armV[0] = 1'b0;
    for (int k = 0; k < 32; k++) begin
      if (k <= 16) begin
        checks++;
        if (stateV[0] !== 2'd1) begin errors++; $display("FAIL trig_armed%0d got %0d exp 1", k, stateV[0]); end
      end
      sampleEn = 1'b1;
      nextPc   = 32'(4 * k);
      ctrlCode = 12'(k);
      @(negedge clk);
    end
    sampleEn = 1'b0;
    checks++;
    if ({doneV[0], countV[0]} !== {1'b1, 5'd16}) begin
      errors++; $display("FAIL trig_done got done=%b count=%0d exp 1/16", doneV[0], countV[0]);
    end
    rdReqV[0] = 1'b1;
    @(negedge clk);
    rdReqV[0] = 1'b0;
    r = rdDataV[0];
    checks++;
    if (rdValidV[0] !== 1'b1 || r[OFF_NEXT_PC +: 32] !== 32'h40 || r[OFF_TS +: 16] !== 16'd0 ||
        r[OFF_CTRL +: 12] !== 12'd16) begin
      errors++; $display("FAIL trig_rec0 got valid=%b pc=%h ts=%0d ctrl=%0d exp 1/40/0/16", rdValidV[0],
                         r[OFF_NEXT_PC +: 32], r[OFF_TS +: 16], r[OFF_CTRL +: 12]);
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int g = 0; g < NDUT; g++) begin
      armV[g]   = 1'b0;
      rdReqV[g] = 1'b0;
    end
    modeWrap = 1'b0; sampleEn = 1'b0; ctrlCode = '0; memAddr = '0; memData = '0;
    brAddr = '0; brData = '0; nextPc = '0; instrIf = '0; instrId = '0;
    test_reset();
    test_basic();
    test_wrap();
    test_no_limit();
    test_toggle();
    test_rearm();
    test_reset_mid();
`ifdef TRACE_TRIGGER_PC_EN
    test_trigger();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips32_trace_buffer.md
Name: mips32_trace_buffer

Overview:
Synthesizable, parametrised on-chip trace capture for the mips32 pipeline top.
- Each qualified cycle, it samples the CPU debug taps (ID control code, MEM address/data, WB destination register/value, next PC, IF/ID instructions) plus a cycle timestamp.
- Samples go into a circular buffer, and capture stops after a programmable sample limit.
- Adds stop-on-full vs. wrap modes and a read-back handshake, replacing per-cycle simulator printing as the way to inspect pipeline state on hardware.

Parameters:
- DEPTH, 16, number of records stored; power of two, ≥2.
- RUN_LIMIT, 16, samples taken before auto-stop; 0 means unlimited.
- CTRL_W, 12, control code width.
- MEM_ADDR_W, 14, data memory address width.
- DATA_W, 32, memory/register data width.
- REG_ADDR_W, 5, register-file address width.
- PC_W, 32, next-PC width.
- INSTR_W, 32, instruction width.
- TS_W, 16, timestamp width.
- TRIGGER_PC, 32'h0, trigger address; used only with TRACE_TRIGGER_PC_EN.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- arm  in  1  start-capture pulse
- mode_wrap  in  1  1 = overwrite oldest record when full; sampled on arm
- sample_en  in  1  capture qualifier (low while the CPU is stalled)
- ctrl_code  in  CTRL_W  ID-stage control code
- mem_addr  in  MEM_ADDR_W  memory address
- mem_data  in  DATA_W  memory data
- br_addr  in  REG_ADDR_W  WB destination register
- br_data  in  DATA_W  WB value
- next_pc  in  PC_W  next PC
- instr_if  in  INSTR_W  IF-stage instruction
- instr_id  in  INSTR_W  ID-stage instruction
- rd_req  in  1  read-one-record request
- rd_valid  out  1  rd_data valid (one-cycle pulse)
- rd_data  out  REC_W  packed record, where REC_W = TS_W+CTRL_W+MEM_ADDR_W+2*DATA_W+REG_ADDR_W+PC_W+2*INSTR_W
- rd_last  out  1  the record being returned is the last one stored
- count  out  clog2(DEPTH)+1  records held
- state  out  2  FSM state
- done  out  1  capture finished
- overflow  out  1  sticky: at least one record was overwritten

Behaviour:
- Reset values:
  - Outputs: state=IDLE; count=0; done, overflow, rd_valid and rd_last all 0; rd_data=0.
  - Internal: wr_ptr=0, rd_ptr=0, timestamp=0, sample counter=0.
  - Reset during any state aborts the operation and discards the contents.
- States:
  - IDLE=0: waits for arm.
  - ARMED=1: used only with the macro.
  - CAPTURE=2.
  - DONE=3.
- IDLE + arm: clear count, pointers, overflow and timestamp; latch mode_wrap; go to CAPTURE next cycle.
- CAPTURE:
  - The timestamp increments every cycle. The first CAPTURE cycle has timestamp 0.
  - When sample_en=1, the record {ts, ctrl_code, mem_addr, mem_data, br_addr, br_data, next_pc, instr_if, instr_id} (MSB→LSB) is written at wr_ptr on that edge, and wr_ptr wraps modulo DEPTH.
  - If count<DEPTH, count increments.
  - If count==DEPTH and mode_wrap=1: the oldest record is overwritten, rd_ptr advances, count stays DEPTH, and overflow is set to 1.
- Exit CAPTURE → DONE on the edge that writes:
  - the RUN_LIMIT-th sample (when RUN_LIMIT≠0), or
  - the DEPTH-th record (when mode_wrap=0).
  - If both conditions hit on the same edge, a single transition occurs.
- arm while in ARMED, CAPTURE or DONE with count>0 is ignored. arm in DONE with count==0 re-arms, following the same path as IDLE.
- DONE:
  - done=1.
  - rd_req with count>0: one cycle later rd_valid=1 and rd_data holds the record at rd_ptr (oldest first). rd_ptr then advances and count decrements.
  - rd_last=1 together with rd_valid when the returned record was the only one left.
  - rd_req with count==0 is ignored.
  - rd_req outside DONE is ignored.
  - Back-to-back rd_req gives one record per cycle.
  - rd_data holds its value after rd_valid drops.
- Timestamp wraps silently at 2^TS_W.
- RAM: synchronous read, one-cycle latency.

Optional Feature:
TRACE_TRIGGER_PC_EN
- Defined: arm moves IDLE → ARMED. ARMED moves to CAPTURE in the cycle where next_pc==TRIGGER_PC and sample_en=1; that cycle's sample is record 0 with ts=0.
- Undefined: ARMED is unreachable, TRIGGER_PC is unused, and arm goes directly to CAPTURE.

Decomposition:
- Package mips32_trace_pkg holds:
  - the state encoding constants;
  - the field-width defaults;
  - the REC_W function;
  - the field offset constants used for packing and unpacking in benches.
- One sub-module: mips32_trace_ram, a simple dual-port synchronous RAM of DEPTH×REC_W with one write port and one read port.

Test Plan:
- Defaults, arm, then 16 cycles with ctrl_code=0..15 and sample_en=1 → done after the 16th write, count=16, overflow=0. 16 rd_req return ctrl 0..15 with ts 0..15, and rd_last only on the 16th.
- mode_wrap=1, RUN_LIMIT=20, ctrl_code=0..19 → overflow=1, count=16, read-back returns ctrl 4..19.
- RUN_LIMIT=0, mode_wrap=0 → DONE after exactly 16 samples; further inputs are not recorded.
- sample_en toggling 1,0,1,0 for 16 cycles with RUN_LIMIT=8 → 8 records with ts 0,2,4,…,14.
- rst asserted after 5 samples → every output returns to its reset value; a following rd_req produces no rd_valid.
- With TRACE_TRIGGER_PC_EN and TRIGGER_PC=32'h40, next_pc stepping by 4 from 0 → state=ARMED until next_pc=0x40. Record 0 has next_pc 0x40 and ts 0.
